tcp_rx_ctrl: RTL and testbench
==============================

# tcp_rx_ctrl

Receive-side control FSM for the slow-path TCP engine. It takes one parsed TCP header at a time from the RX pipe and resolves its flow ID through the flow table. It reads the flow's RX and TX state, has the datapath compute the updates, writes back the RX state and the acked TX pointer, and requests an ACK from the TX scheduler when needed. It drives only handshakes and datapath strobes; headers and state move through the companion rx datapath.

## Interface
- STAT_W, 32, width of the saturating statistics counters
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rx_pkt_val / rx_pkt_rdy  in/out  1/1  parsed header from RX pipe
- flow_lookup_req_val / flow_lookup_req_rdy  out/in  1/1  flow-table lookup request
- flow_lookup_resp_val / flow_lookup_resp_rdy  in/out  1/1  lookup response
- flow_lookup_resp_hit  in  1  flow found; qualifies resp_val
- rx_state_rd_req_val / rx_state_rd_req_rdy  out/in  1/1  RX state read request
- rx_state_rd_resp_val / rx_state_rd_resp_rdy  in/out  1/1  RX state read response
- tx_state_rd_req_val / tx_state_rd_req_rdy  out/in  1/1  TX state read request
- tx_state_rd_resp_val / tx_state_rd_resp_rdy  in/out  1/1  TX state read response
- rx_state_wr_req_val / rx_state_wr_req_rdy  out/in  1/1  RX state writeback
- tx_ack_ptr_wr_req_val / tx_ack_ptr_wr_req_rdy  out/in  1/1  TX acked-pointer writeback
- sched_ack_req_val / sched_ack_req_rdy  out/in  1/1  ask TX scheduler to send an ACK
- datap_ctrl_in_order  in  1  segment seq equals expected seq; valid in CALC
- datap_ctrl_ack_adv  in  1  ACK field advances the TX acked pointer; valid in CALC
- datap_ctrl_need_ack  in  1  segment carries payload or FIN; valid in CALC
- ctrl_datap_store_hdr  out  1  capture header
- ctrl_datap_store_flowid  out  1  capture lookup result
- ctrl_datap_store_rx_state / ctrl_datap_store_tx_state  out  1/1  capture read data
- ctrl_datap_store_calc  out  1  capture computed next state
- stat_miss_cnt / stat_ooo_cnt  out  STAT_W/STAT_W  lookup misses / out-of-order segments

## Operation
- States: IDLE, LOOKUP, WAIT_LOOKUP, RD_STATE, WAIT_STATE, CALC, WRITEBACK, SCHED_ACK.
- **IDLE.** Drives rx_pkt_rdy=1 and store_hdr=1. On rx_pkt_val the FSM goes to LOOKUP.
- **LOOKUP.** Drives flow_lookup_req_val=1. On rdy the FSM goes to WAIT_LOOKUP.
- **WAIT_LOOKUP.** Drives flow_lookup_resp_rdy=1.
  - On resp_val with hit: store_flowid=1, go to RD_STATE.
  - On resp_val without hit: stat_miss_cnt+1, go to IDLE. The packet is dropped and no state access occurs.
- **RD_STATE.** Both read requests are issued in parallel.
  - Each request has a sticky done flag. A request's val is held until val&rdy, then dropped.
  - The FSM goes to WAIT_STATE in the cycle both handshakes are complete (same cycle or split). No request is ever issued twice.
- **WAIT_STATE.** Both resp_rdy are held high until the respective resp_val.
  - The matching store_*_state pulses in the handshake cycle.
  - Per-response done flags apply. The FSM goes to CALC when both are captured.
- **CALC.** One cycle, store_calc=1.
  - The controller registers in_order, ack_adv and need_ack.
  - If !in_order, stat_ooo_cnt+1.
- **WRITEBACK.**
  - rx_state_wr_req_val is driven only if in_order. tx_ack_ptr_wr_req_val is driven only if ack_adv.
  - Done-flag scheme as in RD_STATE.
  - Exits when all required writes are done. With none required it exits after exactly 1 cycle.
  - Exit goes to SCHED_ACK if need_ack, else to IDLE.
- **SCHED_ACK.** Drives sched_ack_req_val. On rdy the FSM goes to IDLE. An out-of-order segment with payload still requests an ACK (duplicate ACK).
- **Counters.** STAT_W-bit, saturate at all-ones (no wrap). At most one increments per cycle.
- **Outputs.** All val/rdy/strobe outputs are 0 in states where they are not listed above.

## Timing
- **Reset.** rst sampled high:
  - state=IDLE; all done flags, registered datapath flags and both counters are cleared.
  - While rst is high, every val, rdy and strobe output is forced to 0.
  - Reset mid-operation abandons the packet with no writeback.
- **Latency.** With all peers always ready and responses returned the cycle after request, the hit path with writes and ACK is 8 cycles from rx_pkt accept to next rx_pkt_rdy.
- **Miss path.** 3 cycles.
- **Handshakes.** A transfer occurs on val&rdy at the clock edge.
  - Once asserted, val is held until the transfer and is never conditioned on rdy.
  - resp_rdy may be asserted before resp_val.
- **Single outstanding packet.** rx_pkt_rdy=0 outside IDLE.

## Test plan
- **Lookup miss.** Header, then resp_val with hit=0 -> no state reads; stat_miss_cnt 0→1; rx_pkt_rdy=1 three cycles after accept.
- **In-order data segment.** Peers always ready, in_order=1, ack_adv=1, need_ack=1 -> both writes once, one sched_ack_req, next accept at cycle 8; counters unchanged.
- **Split read readiness.** rx_state_rd_req_rdy at cycle 0, tx_state_rd_req_rdy three cycles later -> exactly one handshake each; rx req val low after its handshake; WAIT_STATE entered after the second.
- **Out-of-order segment with payload.** in_order=0, ack_adv=0, need_ack=1 -> no writes; WRITEBACK lasts 1 cycle; sched_ack_req issued; stat_ooo_cnt+1.
- **Counter saturation.** STAT_W=4, 17 misses -> stat_miss_cnt=15.
- **Reset during WRITEBACK with rx_state_wr_req_rdy=0.** -> next cycle all outputs 0, state IDLE, counters 0; the subsequent packet processes normally.

Source files
------------

// File: rtl/tcp_rx_ctrl_if.sv
// Handshake, datapath-strobe and statistics bundle between tcp_rx_ctrl and its peers.
interface tcp_rx_ctrl_if #(
    parameter int unsigned STAT_W = 32
);
    logic              rx_pkt_val;
    logic              rx_pkt_rdy;
    logic              flow_lookup_req_val;
    logic              flow_lookup_req_rdy;
    logic              flow_lookup_resp_val;
    logic              flow_lookup_resp_rdy;
    logic              flow_lookup_resp_hit;
    logic              rx_state_rd_req_val;
    logic              rx_state_rd_req_rdy;
    logic              rx_state_rd_resp_val;
    logic              rx_state_rd_resp_rdy;
    logic              tx_state_rd_req_val;
    logic              tx_state_rd_req_rdy;
    logic              tx_state_rd_resp_val;
    logic              tx_state_rd_resp_rdy;
    logic              rx_state_wr_req_val;
    logic              rx_state_wr_req_rdy;
    logic              tx_ack_ptr_wr_req_val;
    logic              tx_ack_ptr_wr_req_rdy;
    logic              sched_ack_req_val;
    logic              sched_ack_req_rdy;
    logic              datap_ctrl_in_order;
    logic              datap_ctrl_ack_adv;
    logic              datap_ctrl_need_ack;
    logic              ctrl_datap_store_hdr;
    logic              ctrl_datap_store_flowid;
    logic              ctrl_datap_store_rx_state;
    logic              ctrl_datap_store_tx_state;
    logic              ctrl_datap_store_calc;
    logic [STAT_W-1:0] stat_miss_cnt;
    logic [STAT_W-1:0] stat_ooo_cnt;

    modport master (
        input  rx_pkt_val, flow_lookup_req_rdy, flow_lookup_resp_val, flow_lookup_resp_hit,
               rx_state_rd_req_rdy, rx_state_rd_resp_val, tx_state_rd_req_rdy, tx_state_rd_resp_val,
               rx_state_wr_req_rdy, tx_ack_ptr_wr_req_rdy, sched_ack_req_rdy,
               datap_ctrl_in_order, datap_ctrl_ack_adv, datap_ctrl_need_ack,
        output rx_pkt_rdy, flow_lookup_req_val, flow_lookup_resp_rdy,
               rx_state_rd_req_val, rx_state_rd_resp_rdy, tx_state_rd_req_val, tx_state_rd_resp_rdy,
               rx_state_wr_req_val, tx_ack_ptr_wr_req_val, sched_ack_req_val,
               ctrl_datap_store_hdr, ctrl_datap_store_flowid, ctrl_datap_store_rx_state,
               ctrl_datap_store_tx_state, ctrl_datap_store_calc, stat_miss_cnt, stat_ooo_cnt
    );

    modport slave (
        output rx_pkt_val, flow_lookup_req_rdy, flow_lookup_resp_val, flow_lookup_resp_hit,
               rx_state_rd_req_rdy, rx_state_rd_resp_val, tx_state_rd_req_rdy, tx_state_rd_resp_val,
               rx_state_wr_req_rdy, tx_ack_ptr_wr_req_rdy, sched_ack_req_rdy,
               datap_ctrl_in_order, datap_ctrl_ack_adv, datap_ctrl_need_ack,
        input  rx_pkt_rdy, flow_lookup_req_val, flow_lookup_resp_rdy,
               rx_state_rd_req_val, rx_state_rd_resp_rdy, tx_state_rd_req_val, tx_state_rd_resp_rdy,
               rx_state_wr_req_val, tx_ack_ptr_wr_req_val, sched_ack_req_val,
               ctrl_datap_store_hdr, ctrl_datap_store_flowid, ctrl_datap_store_rx_state,
               ctrl_datap_store_tx_state, ctrl_datap_store_calc, stat_miss_cnt, stat_ooo_cnt
    );
endinterface

// File: rtl/tcp_rx_ctrl.sv
// Receive-side control FSM: sequences flow lookup, RX/TX state reads, writeback
// and ACK scheduling for one parsed TCP header at a time.
module tcp_rx_ctrl #(
    parameter int unsigned STAT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    tcp_rx_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, LOOKUP, WAIT_LOOKUP, RD_STATE, WAIT_STATE, CALC, WRITEBACK, SCHED_ACK
    } state_t;

    state_t            state_q, state_d, seq_next;
    logic              rx_done_q, rx_done_d, tx_done_q, tx_done_d;
    logic              in_order_q, in_order_d, ack_adv_q, ack_adv_d, need_ack_q, need_ack_d;
    logic [STAT_W-1:0] miss_q, miss_d, ooo_q, ooo_d;
    logic              seq_active, rx_fin, tx_fin;
    logic              pkt_rdy, lk_req_val, lk_resp_rdy;
    logic              rx_rd_req_val, tx_rd_req_val, rx_rd_resp_rdy, tx_rd_resp_rdy;
    logic              rx_wr_req_val, tx_wr_req_val, ack_req_val;
    logic              st_hdr, st_flowid, st_rx, st_tx, st_calc;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    // Next-state and Moore output decode; paired rx/tx phases share the done-flag logic.
    always_comb begin
        state_d        = state_q;
        rx_done_d      = rx_done_q;
        tx_done_d      = tx_done_q;
        in_order_d     = in_order_q;
        ack_adv_d      = ack_adv_q;
        need_ack_d     = need_ack_q;
        miss_d         = miss_q;
        ooo_d          = ooo_q;
        seq_active     = 1'b0;
        seq_next       = IDLE;
        rx_fin         = 1'b0;
        tx_fin         = 1'b0;
        pkt_rdy        = 1'b0;
        lk_req_val     = 1'b0;
        lk_resp_rdy    = 1'b0;
        rx_rd_req_val  = 1'b0;
        tx_rd_req_val  = 1'b0;
        rx_rd_resp_rdy = 1'b0;
        tx_rd_resp_rdy = 1'b0;
        rx_wr_req_val  = 1'b0;
        tx_wr_req_val  = 1'b0;
        ack_req_val    = 1'b0;
        st_hdr         = 1'b0;
        st_flowid      = 1'b0;
        st_rx          = 1'b0;
        st_tx          = 1'b0;
        st_calc        = 1'b0;

        case (state_q)
            IDLE: begin
                pkt_rdy = 1'b1;
                st_hdr  = 1'b1;
                if (bus.rx_pkt_val) state_d = LOOKUP;
            end
            LOOKUP: begin
                lk_req_val = 1'b1;
                if (bus.flow_lookup_req_rdy) state_d = WAIT_LOOKUP;
            end
            WAIT_LOOKUP: begin
                lk_resp_rdy = 1'b1;
                if (bus.flow_lookup_resp_val) begin
                    if (bus.flow_lookup_resp_hit) begin
                        st_flowid = 1'b1;
                        state_d   = RD_STATE;
                    end else begin
                        miss_d  = sat_inc(miss_q);
                        state_d = IDLE;
                    end
                end
            end
            RD_STATE: begin
                rx_rd_req_val = !rx_done_q;
                tx_rd_req_val = !tx_done_q;
                rx_fin        = rx_done_q || bus.rx_state_rd_req_rdy;
                tx_fin        = tx_done_q || bus.tx_state_rd_req_rdy;
                seq_active    = 1'b1;
                seq_next      = WAIT_STATE;
            end
            WAIT_STATE: begin
                rx_rd_resp_rdy = !rx_done_q;
                tx_rd_resp_rdy = !tx_done_q;
                st_rx          = !rx_done_q && bus.rx_state_rd_resp_val;
                st_tx          = !tx_done_q && bus.tx_state_rd_resp_val;
                rx_fin         = rx_done_q || bus.rx_state_rd_resp_val;
                tx_fin         = tx_done_q || bus.tx_state_rd_resp_val;
                seq_active     = 1'b1;
                seq_next       = CALC;
            end
            CALC: begin
                st_calc    = 1'b1;
                in_order_d = bus.datap_ctrl_in_order;
                ack_adv_d  = bus.datap_ctrl_ack_adv;
                need_ack_d = bus.datap_ctrl_need_ack;
                if (!bus.datap_ctrl_in_order) ooo_d = sat_inc(ooo_q);
                state_d = WRITEBACK;
            end
            WRITEBACK: begin
                // A write that is not required counts as already done.
                rx_wr_req_val = in_order_q && !rx_done_q;
                tx_wr_req_val = ack_adv_q && !tx_done_q;
                rx_fin        = !in_order_q || rx_done_q || bus.rx_state_wr_req_rdy;
                tx_fin        = !ack_adv_q || tx_done_q || bus.tx_ack_ptr_wr_req_rdy;
                seq_active    = 1'b1;
                seq_next      = need_ack_q ? SCHED_ACK : IDLE;
            end
            SCHED_ACK: begin
                ack_req_val = 1'b1;
                if (bus.sched_ack_req_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (seq_active) begin
            if (rx_fin && tx_fin) begin
                state_d   = seq_next;
                rx_done_d = 1'b0;
                tx_done_d = 1'b0;
            end else begin
                rx_done_d = rx_fin;
                tx_done_d = tx_fin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            in_order_q <= 1'b0;
            ack_adv_q  <= 1'b0;
            need_ack_q <= 1'b0;
            miss_q     <= '0;
            ooo_q      <= '0;
        end else begin
            state_q    <= state_d;
            rx_done_q  <= rx_done_d;
            tx_done_q  <= tx_done_d;
            in_order_q <= in_order_d;
            ack_adv_q  <= ack_adv_d;
            need_ack_q <= need_ack_d;
            miss_q     <= miss_d;
            ooo_q      <= ooo_d;
        end
    end

    // Every handshake and strobe is held low while reset is asserted.
    assign bus.rx_pkt_rdy                = pkt_rdy        & ~rst;
    assign bus.flow_lookup_req_val       = lk_req_val     & ~rst;
    assign bus.flow_lookup_resp_rdy      = lk_resp_rdy    & ~rst;
    assign bus.rx_state_rd_req_val       = rx_rd_req_val  & ~rst;
    assign bus.tx_state_rd_req_val       = tx_rd_req_val  & ~rst;
    assign bus.rx_state_rd_resp_rdy      = rx_rd_resp_rdy & ~rst;
    assign bus.tx_state_rd_resp_rdy      = tx_rd_resp_rdy & ~rst;
    assign bus.rx_state_wr_req_val       = rx_wr_req_val  & ~rst;
    assign bus.tx_ack_ptr_wr_req_val     = tx_wr_req_val  & ~rst;
    assign bus.sched_ack_req_val         = ack_req_val    & ~rst;
    assign bus.ctrl_datap_store_hdr      = st_hdr         & ~rst;
    assign bus.ctrl_datap_store_flowid   = st_flowid      & ~rst;
    assign bus.ctrl_datap_store_rx_state = st_rx          & ~rst;
    assign bus.ctrl_datap_store_tx_state = st_tx          & ~rst;
    assign bus.ctrl_datap_store_calc     = st_calc        & ~rst;
    assign bus.stat_miss_cnt             = miss_q;
    assign bus.stat_ooo_cnt              = ooo_q;
endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// Scoreboard bench for tcp_rx_ctrl: expected handshake sequences are queued per
// packet and matched against observed transfers; latency and counters checked per scenario.
`timescale 1ns/1ps
module tb_tcp_rx_ctrl;
    localparam int unsigned STAT_W = 32;
    localparam int unsigned SAT_W  = 4;
    localparam int NCH       = 6;
    localparam int EV_LOOKUP = 0;
    localparam int EV_RXRD   = 1;
    localparam int EV_TXRD   = 2;
    localparam int EV_RXWR   = 3;
    localparam int EV_TXWR   = 4;
    localparam int EV_ACK    = 5;
    localparam logic [14:0] IDLE_OUTS = 15'h4010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int cyc = 0;
    int exp_miss = 0;
    int exp_ooo = 0;

    tcp_rx_ctrl_if #(.STAT_W(STAT_W)) bus ();
    tcp_rx_ctrl_if #(.STAT_W(SAT_W))  sbus ();

    tcp_rx_ctrl #(.STAT_W(STAT_W)) dut     (.clk(clk), .rst(rst), .bus(bus));
    tcp_rx_ctrl #(.STAT_W(SAT_W))  dut_sat (.clk(clk), .rst(rst), .bus(sbus));

    // Peer model state for the main instance
    logic [NCH-1:0] req_val;
    logic [NCH-1:0] req_rdy = '0;
    logic lk_pend = 1'b0, rx_pend = 1'b0, tx_pend = 1'b0;
    logic lk_rv = 1'b0, rx_rv = 1'b0, tx_rv = 1'b0;
    int dly [NCH];
    int cnt [NCH];

    // Monitor state
    logic in_pkt = 1'b0, rxrd_seen = 1'b0, rxval_after = 1'b0;
    int acc_cyc = 0, acc_n = 0, done_n = 0, last_lat = 0;
    int txrd_cyc = -1, wait_cyc = -1, mon_e = 0, s_miss_n = 0;
    logic sat_val = 1'b0;

    assign req_val = {bus.sched_ack_req_val, bus.tx_ack_ptr_wr_req_val, bus.rx_state_wr_req_val,
                      bus.tx_state_rd_req_val, bus.rx_state_rd_req_val, bus.flow_lookup_req_val};
    assign bus.flow_lookup_req_rdy   = req_rdy[EV_LOOKUP];
    assign bus.rx_state_rd_req_rdy   = req_rdy[EV_RXRD];
    assign bus.tx_state_rd_req_rdy   = req_rdy[EV_TXRD];
    assign bus.rx_state_wr_req_rdy   = req_rdy[EV_RXWR];
    assign bus.tx_ack_ptr_wr_req_rdy = req_rdy[EV_TXWR];
    assign bus.sched_ack_req_rdy     = req_rdy[EV_ACK];
    assign bus.flow_lookup_resp_val  = lk_rv;
    assign bus.rx_state_rd_resp_val  = rx_rv;
    assign bus.tx_state_rd_resp_val  = tx_rv;

    // Saturation instance: every lookup misses at once
    assign sbus.rx_pkt_val            = sat_val;
    assign sbus.flow_lookup_req_rdy   = 1'b1;
    assign sbus.flow_lookup_resp_val  = 1'b1;
    assign sbus.flow_lookup_resp_hit  = 1'b0;
    assign sbus.rx_state_rd_req_rdy   = 1'b0;
    assign sbus.rx_state_rd_resp_val  = 1'b0;
    assign sbus.tx_state_rd_req_rdy   = 1'b0;
    assign sbus.tx_state_rd_resp_val  = 1'b0;
    assign sbus.rx_state_wr_req_rdy   = 1'b0;
    assign sbus.tx_ack_ptr_wr_req_rdy = 1'b0;
    assign sbus.sched_ack_req_rdy     = 1'b0;
    assign sbus.datap_ctrl_in_order   = 1'b0;
    assign sbus.datap_ctrl_ack_adv    = 1'b0;
    assign sbus.datap_ctrl_need_ack   = 1'b0;

    // Peer drive: ready after dly[] cycles of val, responses the cycle after request
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        for (int i = 0; i < NCH; i++) req_rdy[i] = req_val[i] && (cnt[i] >= dly[i]);
        lk_rv = lk_pend;
        rx_rv = rx_pend;
        tx_rv = tx_pend;
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) cnt[i] = 0;
            lk_pend = 1'b0;
            rx_pend = 1'b0;
            tx_pend = 1'b0;
            in_pkt  = 1'b0;
        end else begin
            if (in_pkt && bus.rx_pkt_rdy) begin
                last_lat = cyc - acc_cyc;
                in_pkt   = 1'b0;
                done_n++;
            end
            if (bus.rx_pkt_val && bus.rx_pkt_rdy) begin
                in_pkt      = 1'b1;
                acc_cyc     = cyc;
                acc_n++;
                rxrd_seen   = 1'b0;
                rxval_after = 1'b0;
                txrd_cyc    = -1;
                wait_cyc    = -1;
            end
            if (rxrd_seen && bus.rx_state_rd_req_val) rxval_after = 1'b1;
            if (wait_cyc < 0 && bus.tx_state_rd_resp_rdy) wait_cyc = cyc;
            for (int i = 0; i < NCH; i++) begin
                if (req_val[i] && req_rdy[i]) begin
                    cnt[i] = 0;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL event: handshake on channel %0d at cycle %0d, required none", i, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e != i) begin
                            n_err++;
                            $display("FAIL event: handshake on channel %0d, required channel %0d", i, mon_e);
                        end
                    end
                end else if (req_val[i]) begin
                    cnt[i] = cnt[i] + 1;
                end
            end
            if (req_val[EV_LOOKUP] && req_rdy[EV_LOOKUP]) lk_pend = 1'b1;
            if (req_val[EV_RXRD] && req_rdy[EV_RXRD]) begin rx_pend = 1'b1; rxrd_seen = 1'b1; end
            if (req_val[EV_TXRD] && req_rdy[EV_TXRD]) begin tx_pend = 1'b1; txrd_cyc = cyc; end
            if (bus.flow_lookup_resp_val && bus.flow_lookup_resp_rdy) lk_pend = 1'b0;
            if (bus.rx_state_rd_resp_val && bus.rx_state_rd_resp_rdy) rx_pend = 1'b0;
            if (bus.tx_state_rd_resp_val && bus.tx_state_rd_resp_rdy) tx_pend = 1'b0;
            if (sbus.flow_lookup_resp_val && sbus.flow_lookup_resp_rdy) s_miss_n++;
        end
    end

    function automatic logic [14:0] outs();
        return {bus.rx_pkt_rdy, req_val, bus.flow_lookup_resp_rdy, bus.rx_state_rd_resp_rdy,
                bus.tx_state_rd_resp_rdy, bus.ctrl_datap_store_hdr, bus.ctrl_datap_store_flowid,
                bus.ctrl_datap_store_rx_state, bus.ctrl_datap_store_tx_state, bus.ctrl_datap_store_calc};
    endfunction

    // Queue the expected handshakes, send one header, wait for the return to IDLE
    task automatic run_pkt(input logic hit, input logic io, input logic aa, input logic na,
                           output int lat, output bit to);
        int a0, d0;
        exp_q.push_back(EV_LOOKUP);
        if (hit) begin
            exp_q.push_back(EV_RXRD);
            exp_q.push_back(EV_TXRD);
            if (io) exp_q.push_back(EV_RXWR);
            if (aa) exp_q.push_back(EV_TXWR);
            if (na) exp_q.push_back(EV_ACK);
        end
        bus.flow_lookup_resp_hit = hit;
        bus.datap_ctrl_in_order  = io;
        bus.datap_ctrl_ack_adv   = aa;
        bus.datap_ctrl_need_ack  = na;
        a0 = acc_n;
        d0 = done_n;
        @(posedge clk); #1;
        bus.rx_pkt_val = 1'b1;
        for (int i = 0; i < 10 && acc_n == a0; i++) begin @(negedge clk); #1; end
        @(posedge clk); #1;
        bus.rx_pkt_val = 1'b0;
        for (int i = 0; i < 200 && done_n == d0; i++) begin @(negedge clk); #1; end
        to  = (done_n == d0);
        lat = last_lat;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_vec++;
        if (outs() !== 15'h0) begin n_err++; $display("FAIL reset_outs_during_rst: got %h, required %h", outs(), 15'h0); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if (outs() !== IDLE_OUTS) begin n_err++; $display("FAIL reset_idle_outs: got %h, required %h", outs(), IDLE_OUTS); end
        n_vec++;
        if (bus.stat_miss_cnt !== '0 || bus.stat_ooo_cnt !== '0) begin
            n_err++; $display("FAIL reset_counters: got miss %0d ooo %0d, required 0 0", bus.stat_miss_cnt, bus.stat_ooo_cnt);
        end
        n_vec++;
        if (sbus.stat_miss_cnt !== '0) begin n_err++; $display("FAIL reset_sat_counter: got %0d, required 0", sbus.stat_miss_cnt); end
    endtask

    task automatic test_lookup_miss();
        int lat; bit to;
        run_pkt(1'b0, 1'b0, 1'b0, 1'b0, lat, to);
        exp_miss++;
        n_vec++;
        if (to || lat !== 3) begin n_err++; $display("FAIL miss_latency: got %0d (timeout %0d), required 3", lat, to); end
        n_vec++;
        if (bus.stat_miss_cnt !== STAT_W'(exp_miss)) begin n_err++; $display("FAIL miss_count: got %0d, required %0d", bus.stat_miss_cnt, exp_miss); end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL miss_events: %0d handshakes missing, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_in_order();
        int lat; bit to;
        run_pkt(1'b1, 1'b1, 1'b1, 1'b1, lat, to);
        n_vec++;
        if (to || lat !== 8) begin n_err++; $display("FAIL inorder_latency: got %0d (timeout %0d), required 8", lat, to); end
        n_vec++;
        if (bus.stat_miss_cnt !== STAT_W'(exp_miss) || bus.stat_ooo_cnt !== STAT_W'(exp_ooo)) begin
            n_err++; $display("FAIL inorder_counters: got miss %0d ooo %0d, required %0d %0d", bus.stat_miss_cnt, bus.stat_ooo_cnt, exp_miss, exp_ooo);
        end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL inorder_events: %0d handshakes missing, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_split_read();
        int lat; bit to;
        dly[EV_TXRD] = 3;
        run_pkt(1'b1, 1'b1, 1'b1, 1'b1, lat, to);
        dly[EV_TXRD] = 0;
        n_vec++;
        if (to || lat !== 11) begin n_err++; $display("FAIL split_latency: got %0d (timeout %0d), required 11", lat, to); end
        n_vec++;
        if (rxval_after !== 1'b0) begin n_err++; $display("FAIL split_rx_val_drop: got %0d, required 0", rxval_after); end
        n_vec++;
        if (txrd_cyc - acc_cyc !== 6) begin n_err++; $display("FAIL split_tx_handshake_cycle: got %0d, required 6", txrd_cyc - acc_cyc); end
        n_vec++;
        if (wait_cyc !== txrd_cyc + 1) begin n_err++; $display("FAIL split_wait_entry: got %0d, required %0d", wait_cyc, txrd_cyc + 1); end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL split_events: %0d handshakes missing, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_ooo_payload();
        int lat; bit to;
        run_pkt(1'b1, 1'b0, 1'b0, 1'b1, lat, to);
        exp_ooo++;
        n_vec++;
        if (to || lat !== 8) begin n_err++; $display("FAIL ooo_latency: got %0d (timeout %0d), required 8", lat, to); end
        n_vec++;
        if (bus.stat_ooo_cnt !== STAT_W'(exp_ooo)) begin n_err++; $display("FAIL ooo_count: got %0d, required %0d", bus.stat_ooo_cnt, exp_ooo); end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL ooo_events: %0d handshakes missing, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_back_to_back();
        int lat; bit to;
        run_pkt(1'b1, 1'b1, 1'b0, 1'b0, lat, to);
        n_vec++;
        if (to || lat !== 7) begin n_err++; $display("FAIL b2b_rxwr_only_latency: got %0d (timeout %0d), required 7", lat, to); end
        run_pkt(1'b1, 1'b0, 1'b0, 1'b0, lat, to);
        exp_ooo++;
        n_vec++;
        if (to || lat !== 7) begin n_err++; $display("FAIL b2b_no_write_latency: got %0d (timeout %0d), required 7", lat, to); end
        dly[EV_TXWR] = 2;
        run_pkt(1'b1, 1'b1, 1'b1, 1'b0, lat, to);
        dly[EV_TXWR] = 0;
        n_vec++;
        if (to || lat !== 9) begin n_err++; $display("FAIL b2b_slow_txwr_latency: got %0d (timeout %0d), required 9", lat, to); end
        n_vec++;
        if (bus.stat_miss_cnt !== STAT_W'(exp_miss) || bus.stat_ooo_cnt !== STAT_W'(exp_ooo)) begin
            n_err++; $display("FAIL b2b_counters: got miss %0d ooo %0d, required %0d %0d", bus.stat_miss_cnt, bus.stat_ooo_cnt, exp_miss, exp_ooo);
        end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_events: %0d handshakes missing, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_in_writeback();
        int lat; bit to; logic seen;
        seen = 1'b0;
        dly[EV_RXWR] = 1000;
        exp_q.push_back(EV_LOOKUP);
        exp_q.push_back(EV_RXRD);
        exp_q.push_back(EV_TXRD);
        bus.flow_lookup_resp_hit = 1'b1;
        bus.datap_ctrl_in_order  = 1'b1;
        bus.datap_ctrl_ack_adv   = 1'b0;
        bus.datap_ctrl_need_ack  = 1'b0;
        @(posedge clk); #1;
        bus.rx_pkt_val = 1'b1;
        @(posedge clk); #1;
        bus.rx_pkt_val = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); #1; seen = bus.rx_state_wr_req_val; end
        n_vec++;
        if (seen !== 1'b1) begin n_err++; $display("FAIL rstwb_reach_writeback: got %0d, required 1", seen); end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rstwb_events: %0d handshakes missing, required 0", exp_q.size()); end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        n_vec++;
        if (outs() !== 15'h0) begin n_err++; $display("FAIL rstwb_outs_during_rst: got %h, required %h", outs(), 15'h0); end
        @(posedge clk); #1;
        rst = 1'b0;
        dly[EV_RXWR] = 0;
        exp_miss = 0;
        exp_ooo  = 0;
        @(negedge clk); #1;
        n_vec++;
        if (outs() !== IDLE_OUTS) begin n_err++; $display("FAIL rstwb_idle_outs: got %h, required %h", outs(), IDLE_OUTS); end
        n_vec++;
        if (bus.stat_miss_cnt !== '0 || bus.stat_ooo_cnt !== '0) begin
            n_err++; $display("FAIL rstwb_counters: got miss %0d ooo %0d, required 0 0", bus.stat_miss_cnt, bus.stat_ooo_cnt);
        end
        run_pkt(1'b1, 1'b1, 1'b1, 1'b1, lat, to);
        n_vec++;
        if (to || lat !== 8) begin n_err++; $display("FAIL rstwb_next_pkt_latency: got %0d (timeout %0d), required 8", lat, to); end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rstwb_next_pkt_events: %0d handshakes missing, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_saturation();
        int m0;
        m0 = s_miss_n;
        @(posedge clk); #1;
        sat_val = 1'b1;
        for (int i = 0; i < 200 && (s_miss_n - m0) < 17; i++) begin @(negedge clk); #1; end
        @(posedge clk); #1;
        sat_val = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        n_vec++;
        if (s_miss_n - m0 !== 17) begin n_err++; $display("FAIL sat_miss_events: got %0d, required 17", s_miss_n - m0); end
        n_vec++;
        if (sbus.stat_miss_cnt !== SAT_W'(15)) begin n_err++; $display("FAIL sat_miss_count: got %0d, required 15", sbus.stat_miss_cnt); end
        n_vec++;
        if (sbus.stat_ooo_cnt !== '0) begin n_err++; $display("FAIL sat_ooo_count: got %0d, required 0", sbus.stat_ooo_cnt); end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin dly[i] = 0; cnt[i] = 0; end
        bus.rx_pkt_val           = 1'b0;
        bus.flow_lookup_resp_hit = 1'b0;
        bus.datap_ctrl_in_order  = 1'b0;
        bus.datap_ctrl_ack_adv   = 1'b0;
        bus.datap_ctrl_need_ack  = 1'b0;
        test_reset();
        test_lookup_miss();
        test_in_order();
        test_split_read();
        test_ooo_payload();
        test_back_to_back();
        test_reset_in_writeback();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
